// File: rtl/dmem_readback_engine.sv
// dmem_readback_engine: walks a contiguous block of data memory from one start
// command and streams each word out over a valid/ready interface. A credit-gated
// issue stage keeps every outstanding read guaranteed a slot in the output FIFO,
// so memory read latency and consumer backpressure never lose a word.
module dmem_readback_engine #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  descend,
  input  logic                  abort,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_index,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned INF_W = $clog2(MEM_LATENCY + 2);
  localparam int unsigned SUM_W = ((OCC_W > INF_W) ? OCC_W : INF_W) + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  accepted_q;
  logic                  desc_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [CNT_WIDTH-1:0]  mem_index_q;

  logic                  vld_pipe [MEM_LATENCY];
  logic [CNT_WIDTH-1:0]  idx_pipe [MEM_LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]  fifo_idx  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      occ;

  logic [INF_W-1:0]      in_flight;
  logic                  credit_c;
  logic                  push_c, pop_c;
  logic                  issue_c, start_ok_c, start_bad_c, kill_c;
  logic [ADDR_WIDTH-1:0] issue_addr_c, next_addr_c;
  logic                  issue_desc_c;
  logic [CNT_WIDTH-1:0]  issue_idx_c;

  // FIFO head is presented first-word-fall-through; outputs read 0 when empty
  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_index = out_valid ? fifo_idx[rd_ptr]  : '0;
  assign pop_c     = out_valid & out_ready;
  assign push_c    = vld_pipe[MEM_LATENCY-1];

  // Reads outstanding: the request on the port now plus tags still in the pipe
  always_comb begin
    in_flight = INF_W'(mem_enable);
    for (int i = 0; i < int'(MEM_LATENCY); i++) begin
      in_flight = in_flight + INF_W'(vld_pipe[i]);
    end
  end

  // Issue only if the word is guaranteed a FIFO slot when it returns
  assign credit_c = (SUM_W'(occ) + SUM_W'(in_flight)) < SUM_W'(FIFO_DEPTH);

  // Next-state and per-cycle control decisions
  always_comb begin
    state_d     = state_q;
    issue_c     = 1'b0;
    start_ok_c  = 1'b0;
    start_bad_c = 1'b0;
    kill_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if ((word_count == '0) || ((base_addr & ALIGN_MASK) != '0)) begin
            start_bad_c = 1'b1;
          end else begin
            start_ok_c = 1'b1;
            issue_c    = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          kill_c = 1'b1;
        end else if (issued_q == cnt_q) begin
          state_d = S_DRAIN;
        end else if (credit_c) begin
          issue_c = 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          kill_c = 1'b1;
        end else if ((in_flight == '0) && (occ == '0) && (accepted_q == cnt_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        kill_c  = abort;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_c) begin
      state_d = S_IDLE;
    end
  end

  // The first word is issued straight from the start command to save a cycle
  always_comb begin
    issue_addr_c = start_ok_c ? base_addr : cur_addr_q;
    issue_desc_c = start_ok_c ? descend : desc_q;
    issue_idx_c  = start_ok_c ? '0 : issued_q;
    next_addr_c  = issue_desc_c ? (issue_addr_c - STRIDE) : (issue_addr_c + STRIDE);
  end

  // State register and burst bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      desc_q     <= 1'b0;
      cur_addr_q <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok_c) begin
        cnt_q      <= word_count;
        desc_q     <= descend;
        accepted_q <= '0;
      end else if (pop_c) begin
        accepted_q <= accepted_q + CNT_WIDTH'(1);
      end
      if (issue_c) begin
        cur_addr_q <= next_addr_c;
        issued_q   <= issue_idx_c + CNT_WIDTH'(1);
      end
    end
  end

  // Registered read request port; address holds between requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_enable  <= 1'b0;
      mem_address <= '0;
      mem_index_q <= '0;
    end else begin
      mem_enable <= issue_c;
      if (issue_c) begin
        mem_address <= issue_addr_c;
        mem_index_q <= issue_idx_c;
      end
    end
  end

  // Return tag pipe tracks which cycle's mem_read_data belongs to which word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        vld_pipe[i] <= 1'b0;
        idx_pipe[i] <= '0;
      end
    end else if (kill_c) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        vld_pipe[i] <= 1'b0;
      end
    end else begin
      vld_pipe[0] <= mem_enable;
      idx_pipe[0] <= mem_index_q;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; abort flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (kill_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ <= occ + OCC_W'(push_c) - OCC_W'(pop_c);
    end
  end

  // FIFO storage; contents are don't-care until occupancy covers them
  always_ff @(posedge clk) begin
    if (push_c && !kill_c) begin
      fifo_data[wr_ptr] <= mem_read_data;
      fifo_idx[wr_ptr]  <= idx_pipe[MEM_LATENCY-1];
    end
  end

  // Status outputs follow the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      busy  <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done  <= (state_d == S_DONE);
      error <= start_bad_c;
    end
  end

endmodule

// File: tb/tb_dmem_readback_engine.sv
// Bench for dmem_readback_engine: directed stimulus, a queue-based burst model
// checked every cycle, and literal expectations for the headline scenarios.
module tb_dmem_readback_engine;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned WB    = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          descend = 1'b0;
  logic          abort = 1'b0;
  logic          mem_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_read_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_index;
  logic          busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_readback_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_BYTES(WB),
    .CNT_WIDTH(CW), .MEM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .descend(descend), .abort(abort),
    .mem_enable(mem_enable), .mem_address(mem_address),
    .mem_read_data(mem_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done), .error(error)
  );

  // Data memory: word at byte address a holds a/4, returned LAT cycles later
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_enable ? DW'(mem_address >> 2) : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_read_data = rd_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- burst model ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] idx;
  } word_t;

  logic [AW-1:0] q_addr[$];
  word_t         q_out[$];
  bit            e_busy, e_done, e_err, e_quiet, hold;
  int            dly, issued_n, accepted_n;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] hold_idx;

  always @(negedge clk) begin
    bit n_busy, n_done, n_err, cur_idle;
    word_t w;
    logic [AW-1:0] a;
    if (!reset) begin
      q_addr.delete(); q_out.delete();
      e_busy = 0; e_done = 0; e_err = 0; e_quiet = 0; hold = 0;
      dly = 0; issued_n = 0; accepted_n = 0;
    end else begin
      chk("m_busy", busy, e_busy);
      chk("m_done", done, e_done);
      chk("m_error", error, e_err);
      if (e_quiet) begin
        chk("m_abort_mem_enable", mem_enable, 0);
        chk("m_abort_out_valid", out_valid, 0);
      end
      if (hold) begin
        chk("m_hold_valid", out_valid, 1);
        chk("m_hold_data", out_data, hold_data);
        chk("m_hold_index", out_index, hold_idx);
      end
      if (mem_enable) begin
        if (q_addr.size() == 0) chk("m_spurious_issue", mem_enable, 0);
        else begin
          chk("m_mem_address", mem_address, q_addr.pop_front());
          issued_n++;
          chk("m_outstanding_le_depth", (issued_n - accepted_n) <= int'(DEPTH), 1);
        end
      end
      n_busy = e_busy; n_done = 0; n_err = 0;
      cur_idle = !e_busy && !e_done;
      if (out_valid) begin
        if (q_out.size() == 0) chk("m_spurious_out_valid", out_valid, 0);
        else begin
          w = q_out[0];
          chk("m_out_data", out_data, w.data);
          chk("m_out_index", out_index, w.idx);
          if (out_ready) begin
            void'(q_out.pop_front());
            accepted_n++;
            if (q_out.size() == 0 && e_busy && !abort) dly = 2;
          end
        end
      end
      hold = out_valid && !out_ready && !abort;
      hold_data = out_data; hold_idx = out_index;
      e_quiet = 0;
      if (abort && !cur_idle) begin
        q_addr.delete(); q_out.delete();
        dly = 0; n_busy = 0; e_quiet = 1; hold = 0;
      end else if (start && !abort && cur_idle) begin
        if (word_count == 0 || (base_addr % WB) != 0) n_err = 1;
        else begin
          n_busy = 1; issued_n = 0; accepted_n = 0;
          for (int i = 0; i < int'(word_count); i++) begin
            a = descend ? base_addr - AW'(WB * i) : base_addr + AW'(WB * i);
            q_addr.push_back(a);
            w.data = DW'(a >> 2); w.idx = CW'(i);
            q_out.push_back(w);
          end
        end
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin n_done = 1; n_busy = 0; end
      end
      e_busy = n_busy; e_done = n_done; e_err = n_err;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] c, input logic d);
    start = 1; base_addr = b; word_count = c; descend = d;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_within_budget", seen, 1);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_enable"}, mem_enable, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    int n_iss, acc;
    bit seen;
    logic [AW-1:0] wrap_a [4];
    wrap_a[0] = 32'hFFFF_FFF8; wrap_a[1] = 32'hFFFF_FFFC;
    wrap_a[2] = 32'h0000_0000; wrap_a[3] = 32'h0000_0004;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1;
    tick(); tick();

    // Descending dump 4092..4064
    out_ready = 1;
    pulse_start(32'd4092, 8'd8, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("desc_mem_enable", mem_enable, 1);
        chk("desc_mem_address", mem_address, 4092 - 4 * (k - 1));
      end
      if (k < 3) chk("desc_first_valid_early", out_valid, 0);
      if (k >= 3 && k <= 10) begin
        chk("desc_out_valid", out_valid, 1);
        chk("desc_out_data", out_data, 1023 - (k - 3));
        chk("desc_out_index", out_index, k - 3);
      end
      if (k == 11) chk("desc_done_early", done, 0);
      if (k == 12) begin
        chk("desc_done", done, 1);
        chk("desc_busy_with_done", busy, 0);
      end
    end
    tick();

    // Rejected starts
    pulse_start(32'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk("reject_count0_error", error, 1);
    chk("reject_count0_mem_enable", mem_enable, 0);
    tick();
    pulse_start(32'd4090, 8'd4, 1'b0);
    @(negedge clk);
    chk("reject_misaligned_error", error, 1);
    chk("reject_misaligned_mem_enable", mem_enable, 0);
    tick();

    // Start while busy is ignored
    pulse_start(32'h100, 8'd6, 1'b0);
    tick();
    pulse_start(32'h800, 8'd3, 1'b1);
    @(negedge clk);
    chk("busy_start_no_error", error, 0);
    wait_done(100);

    // Backpressure: consumer stalls for cycles 3..12
    n_iss = 0; seen = 0;
    pulse_start(32'h0, 8'd12, 1'b0);
    for (int c = 1; c <= 60 && !seen; c++) begin
      out_ready = !(c >= 3 && c <= 12);
      @(negedge clk);
      if (c <= 12 && mem_enable) n_iss++;
      if (c == 10) begin
        chk("bp_stall_mem_enable", mem_enable, 0);
        chk("bp_stall_out_valid", out_valid, 1);
      end
      if (done) seen = 1;
      tick();
    end
    chk("bp_issued_during_stall", n_iss, DEPTH);
    chk("bp_done", seen, 1);
    out_ready = 1;

    // Address wrap across 2^32
    pulse_start(32'hFFFF_FFF8, 8'd4, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("wrap_mem_address", mem_address, wrap_a[k-1]);
      if (k == 3) chk("wrap_first_data", out_data, 32'h3FFF_FFFE);
    end
    wait_done(50);

    // Abort after the 5th accepted word
    acc = 0;
    pulse_start(32'h200, 8'd16, 1'b0);
    for (int i = 0; i < 100 && acc < 5; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) acc++;
      if (acc < 5) tick();
    end
    chk("abort_reached_5", acc, 5);
    tick();
    abort = 1; out_ready = 0;
    tick();
    abort = 0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_enable", mem_enable, 0);
    chk("abort_no_done", done, 0);
    tick();
    out_ready = 1;
    tick();
    pulse_start(32'h40, 8'd3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("restart_index0", out_index, 0);
        chk("restart_data0", out_data, 32'h10);
      end
    end
    wait_done(50);

    // Reset in the middle of a burst with data buffered
    out_ready = 0;
    pulse_start(32'h1000, 8'd20, 1'b0);
    repeat (4) tick();
    chk("pre_reset_fifo_nonempty", out_valid, 1);
    reset = 0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_reset_idle_busy", busy, 0);
      chk("post_reset_idle_mem_enable", mem_enable, 0);
    end
    tick();
    out_ready = 1;
    pulse_start(32'h20, 8'd2, 1'b1);
    wait_done(50);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
